// File: rtl/axi_pkg.sv
// Purpose: shared types and constants for the AXI line responder (burst kinds, response codes, FSM states).
// Latency: n/a (declarations only).
// Backpressure: n/a.
package axi_pkg;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'd0,
        BURST_INCR  = 2'd1,
        BURST_WRAP  = 2'd2
    } burst_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [3:0] ACSNOOP_MAKE_INVALID = 4'hd;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } rstate_e;

    typedef enum logic [1:0] {
        W_IDLE,
        W_DATA,
        W_RESP,
        W_SNOOP
    } wstate_e;

    // A burst this responder cannot serve as asked: reserved burst type,
    // a beat size other than 8 bytes, or a WRAP whose length is not 2/4/8/16.
    function automatic logic burst_err(input logic [7:0] len,
                                       input logic [2:0] size,
                                       input logic [1:0] burst);
        logic wrap_bad;
        wrap_bad = (burst == BURST_WRAP) &&
                   !((len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15));
        return (burst == 2'd3) || (size != 3'd3) || wrap_bad;
    endfunction

endpackage

// File: rtl/axi_burst_addr.sv
// Purpose: next beat address for FIXED / INCR / WRAP bursts of 8-byte beats.
// Latency: combinational.
// Backpressure: none; caller decides when to advance.
//   addr      in  current beat address
//   len       in  AXI len (beats - 1)
//   burst     in  AXI burst type
//   next_addr out address of the following beat
module axi_burst_addr
    import axi_pkg::*;
#(
    parameter int ADDR_WIDTH = 64
) (
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [7:0]            len,
    input  logic [1:0]            burst,
    output logic [ADDR_WIDTH-1:0] next_addr
);

    logic [ADDR_WIDTH-1:0] incr;
    logic [ADDR_WIDTH-1:0] mask;

    always_comb begin
        incr      = addr + ADDR_WIDTH'(8);
        // For a legal WRAP len (2^n - 1) the window size minus one is {len, 3'b111},
        // so the low bits step and the high bits stay pinned to the window base.
        mask      = ADDR_WIDTH'({len, 3'b111});
        next_addr = incr;
        case (burst)
            BURST_FIXED: next_addr = addr;
            BURST_WRAP:  next_addr = (addr & ~mask) | (incr & mask);
            default:     next_addr = incr;
        endcase
    end

endmodule

// File: rtl/axi_line_responder.sv
// Purpose: AXI slave serving INCR/WRAP/FIXED line bursts from a word RAM; MakeInvalid snoop on AC after each write.
// Latency: AR handshake -> first R beat next cycle; last W -> B next cycle; B handshake -> AC next cycle.
// Backpressure: R/B/AC hold stable until ready; one outstanding burst per channel (arready/awready low while busy).
//   clk, reset           clock, synchronous active-high reset
//   s_axi_ar*/s_axi_r*   read address / read data channels
//   s_axi_aw*/s_axi_w*   write address / write data channels
//   s_axi_b*             write response channel
//   s_axi_ac*            snoop (invalidate) channel, driven by this block
module axi_line_responder
    import axi_pkg::*;
#(
    parameter int ID_WIDTH       = 13,
    parameter int ADDR_WIDTH     = 64,
    parameter int DATA_WIDTH     = 64,
    parameter int STRB_WIDTH     = DATA_WIDTH / 8,
    parameter int MEM_WORDS      = 4096,
    parameter bit SNOOP_ON_WRITE = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ID_WIDTH-1:0]   s_axi_arid,
    input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
    input  logic [7:0]            s_axi_arlen,
    input  logic [2:0]            s_axi_arsize,
    input  logic [1:0]            s_axi_arburst,
    input  logic                  s_axi_arvalid,
    output logic                  s_axi_arready,
    output logic [ID_WIDTH-1:0]   s_axi_rid,
    output logic [DATA_WIDTH-1:0] s_axi_rdata,
    output logic [1:0]            s_axi_rresp,
    output logic                  s_axi_rlast,
    output logic                  s_axi_rvalid,
    input  logic                  s_axi_rready,
    input  logic [ID_WIDTH-1:0]   s_axi_awid,
    input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
    input  logic [7:0]            s_axi_awlen,
    input  logic [2:0]            s_axi_awsize,
    input  logic [1:0]            s_axi_awburst,
    input  logic                  s_axi_awvalid,
    output logic                  s_axi_awready,
    input  logic [DATA_WIDTH-1:0] s_axi_wdata,
    input  logic [STRB_WIDTH-1:0] s_axi_wstrb,
    input  logic                  s_axi_wlast,
    input  logic                  s_axi_wvalid,
    output logic                  s_axi_wready,
    output logic [ID_WIDTH-1:0]   s_axi_bid,
    output logic [1:0]            s_axi_bresp,
    output logic                  s_axi_bvalid,
    input  logic                  s_axi_bready,
    output logic                  s_axi_acvalid,
    input  logic                  s_axi_acready,
    output logic [ADDR_WIDTH-1:0] s_axi_acaddr,
    output logic [3:0]            s_axi_acsnoop
);

    localparam int IDX_W = $clog2(MEM_WORDS);

    logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

    // ---------------- read channel ----------------
    rstate_e               r_state, r_state_nxt;
    logic [ID_WIDTH-1:0]   r_id;
    logic [ADDR_WIDTH-1:0] r_addr, r_addr_nxt;
    logic [7:0]            r_len, r_beat;
    logic [1:0]            r_burst;
    logic                  r_err;
    logic                  ar_hs, r_hs;

    axi_burst_addr #(.ADDR_WIDTH(ADDR_WIDTH)) u_raddr (
        .addr      (r_addr),
        .len       (r_len),
        .burst     (r_burst),
        .next_addr (r_addr_nxt)
    );

    always_comb begin
        r_state_nxt   = r_state;
        s_axi_arready = 1'b0;
        s_axi_rvalid  = 1'b0;
        case (r_state)
            R_IDLE: begin
                s_axi_arready = 1'b1;
                if (s_axi_arvalid) r_state_nxt = R_DATA;
            end
            R_DATA: begin
                s_axi_rvalid = 1'b1;
                if (s_axi_rready && s_axi_rlast) r_state_nxt = R_IDLE;
            end
            default: r_state_nxt = R_IDLE;
        endcase
    end

    assign ar_hs       = s_axi_arvalid && s_axi_arready;
    assign r_hs        = s_axi_rvalid && s_axi_rready;
    assign s_axi_rlast = (r_state == R_DATA) && (r_beat == r_len);
    assign s_axi_rid   = r_id;
    assign s_axi_rresp = r_err ? RESP_SLVERR : RESP_OKAY;
    // Asynchronous read: a write landing on the same edge is seen only from the next cycle.
    assign s_axi_rdata = mem[r_addr[IDX_W+2:3]];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= R_IDLE;
            r_id    <= '0;
            r_addr  <= '0;
            r_len   <= '0;
            r_beat  <= '0;
            r_burst <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= r_state_nxt;
            if (ar_hs) begin
                r_id    <= s_axi_arid;
                r_addr  <= s_axi_araddr;
                r_len   <= s_axi_arlen;
                r_burst <= s_axi_arburst;
                r_beat  <= '0;
                r_err   <= burst_err(s_axi_arlen, s_axi_arsize, s_axi_arburst);
            end else if (r_hs) begin
                r_addr <= r_addr_nxt;
                r_beat <= r_beat + 8'd1;
            end
        end
    end

    // ---------------- write channel ----------------
    wstate_e               w_state, w_state_nxt;
    logic [ID_WIDTH-1:0]   aw_id;
    logic [ADDR_WIDTH-1:0] aw_addr;          // burst start, kept for the snoop address
    logic [ADDR_WIDTH-1:0] w_addr, w_addr_nxt;
    logic [7:0]            aw_len, w_beat;
    logic [1:0]            aw_burst;
    logic                  aw_err, w_mism;
    logic                  aw_hs, w_hs, w_last_beat, w_end;

    axi_burst_addr #(.ADDR_WIDTH(ADDR_WIDTH)) u_waddr (
        .addr      (w_addr),
        .len       (aw_len),
        .burst     (aw_burst),
        .next_addr (w_addr_nxt)
    );

    assign w_last_beat = (w_beat == aw_len);
    // The burst stops at whichever of wlast or the expected final beat comes first.
    assign w_end       = s_axi_wlast || w_last_beat;

    always_comb begin
        w_state_nxt   = w_state;
        s_axi_awready = 1'b0;
        s_axi_wready  = 1'b0;
        s_axi_bvalid  = 1'b0;
        s_axi_acvalid = 1'b0;
        case (w_state)
            W_IDLE: begin
                s_axi_awready = 1'b1;
                if (s_axi_awvalid) w_state_nxt = W_DATA;
            end
            W_DATA: begin
                s_axi_wready = 1'b1;
                if (s_axi_wvalid && w_end) w_state_nxt = W_RESP;
            end
            W_RESP: begin
                s_axi_bvalid = 1'b1;
                if (s_axi_bready) w_state_nxt = SNOOP_ON_WRITE ? W_SNOOP : W_IDLE;
            end
            W_SNOOP: begin
                s_axi_acvalid = 1'b1;
                if (s_axi_acready) w_state_nxt = W_IDLE;
            end
            default: w_state_nxt = W_IDLE;
        endcase
    end

    assign aw_hs         = s_axi_awvalid && s_axi_awready;
    assign w_hs          = s_axi_wvalid && s_axi_wready;
    assign s_axi_bid     = aw_id;
    assign s_axi_bresp   = (aw_err || w_mism) ? RESP_SLVERR : RESP_OKAY;
    assign s_axi_acaddr  = {aw_addr[ADDR_WIDTH-1:6], 6'b0};
    assign s_axi_acsnoop = ACSNOOP_MAKE_INVALID;

    always_ff @(posedge clk) begin
        if (reset) begin
            w_state  <= W_IDLE;
            aw_id    <= '0;
            aw_addr  <= '0;
            w_addr   <= '0;
            aw_len   <= '0;
            aw_burst <= '0;
            w_beat   <= '0;
            aw_err   <= 1'b0;
            w_mism   <= 1'b0;
        end else begin
            w_state <= w_state_nxt;
            if (aw_hs) begin
                aw_id    <= s_axi_awid;
                aw_addr  <= s_axi_awaddr;
                w_addr   <= s_axi_awaddr;
                aw_len   <= s_axi_awlen;
                aw_burst <= s_axi_awburst;
                w_beat   <= '0;
                aw_err   <= burst_err(s_axi_awlen, s_axi_awsize, s_axi_awburst);
                w_mism   <= 1'b0;
            end else if (w_hs) begin
                w_addr <= w_addr_nxt;
                w_beat <= w_beat + 8'd1;
                if (w_end) w_mism <= (s_axi_wlast != w_last_beat);
            end
        end
    end

    // RAM survives reset; a beat racing a reset edge is dropped.
    always_ff @(posedge clk) begin
        if (w_hs && !aw_err && !reset) begin
            for (int b = 0; b < STRB_WIDTH; b++) begin
                if (s_axi_wstrb[b]) mem[w_addr[IDX_W+2:3]][b*8 +: 8] <= s_axi_wdata[b*8 +: 8];
            end
        end
    end

endmodule

// File: tb/tb_axi_line_responder.sv
module tb_axi_line_responder;

    localparam int IW = 13;

    logic        clk = 1'b0;
    logic        reset;
    logic [IW-1:0] s_axi_arid, s_axi_rid, s_axi_awid, s_axi_bid;
    logic [63:0] s_axi_araddr, s_axi_rdata, s_axi_awaddr, s_axi_wdata, s_axi_acaddr;
    logic [7:0]  s_axi_arlen, s_axi_awlen, s_axi_wstrb;
    logic [2:0]  s_axi_arsize, s_axi_awsize;
    logic [1:0]  s_axi_arburst, s_axi_awburst, s_axi_rresp, s_axi_bresp;
    logic        s_axi_arvalid, s_axi_arready, s_axi_rlast, s_axi_rvalid, s_axi_rready;
    logic        s_axi_awvalid, s_axi_awready, s_axi_wlast, s_axi_wvalid, s_axi_wready;
    logic        s_axi_bvalid, s_axi_bready, s_axi_acvalid, s_axi_acready;
    logic [3:0]  s_axi_acsnoop;

    always #5 clk = ~clk;

    axi_line_responder dut (
        .clk(clk), .reset(reset),
        .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
        .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst),
        .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
        .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
        .s_axi_rlast(s_axi_rlast), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
        .s_axi_awid(s_axi_awid), .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
        .s_axi_awsize(s_axi_awsize), .s_axi_awburst(s_axi_awburst),
        .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
        .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
        .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
        .s_axi_bready(s_axi_bready),
        .s_axi_acvalid(s_axi_acvalid), .s_axi_acready(s_axi_acready),
        .s_axi_acaddr(s_axi_acaddr), .s_axi_acsnoop(s_axi_acsnoop)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: no handshake within cycle budget, expected one", name);
    endtask

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [IW-1:0] id;
        logic [63:0]   dat;
        logic [1:0]    resp;
        logic          last;
        logic          chk_dat;
    } rexp_t;

    typedef struct {
        logic [IW-1:0] id;
        logic [1:0]    resp;
    } bexp_t;

    rexp_t       r_q[$];
    bexp_t       b_q[$];
    logic [63:0] ac_q[$];
    rexp_t       rm;
    bexp_t       bm;
    logic [63:0] am;

    always @(negedge clk) begin
        if (!reset) begin
            if (s_axi_rvalid && s_axi_rready) begin
                if (r_q.size() == 0) chk("r_unexpected_beat", s_axi_rvalid, 1'b0);
                else begin
                    rm = r_q.pop_front();
                    chk("rid", s_axi_rid, rm.id);
                    chk("rresp", s_axi_rresp, rm.resp);
                    chk("rlast", s_axi_rlast, rm.last);
                    if (rm.chk_dat) chk("rdata", s_axi_rdata, rm.dat);
                end
            end
            if (s_axi_bvalid && s_axi_bready) begin
                if (b_q.size() == 0) chk("b_unexpected", s_axi_bvalid, 1'b0);
                else begin
                    bm = b_q.pop_front();
                    chk("bid", s_axi_bid, bm.id);
                    chk("bresp", s_axi_bresp, bm.resp);
                end
            end
            if (s_axi_acvalid && s_axi_acready) begin
                if (ac_q.size() == 0) chk("ac_unexpected", s_axi_acvalid, 1'b0);
                else begin
                    am = ac_q.pop_front();
                    chk("acaddr", s_axi_acaddr, am);
                    chk("acsnoop", s_axi_acsnoop, 4'hd);
                end
            end
        end
    end

    task automatic push_r(input logic [IW-1:0] id, input logic [63:0] dat, input logic [1:0] resp,
                          input logic last, input logic chk_dat);
        rexp_t e;
        e.id = id; e.dat = dat; e.resp = resp; e.last = last; e.chk_dat = chk_dat;
        r_q.push_back(e);
    endtask

    task automatic ar_send(input logic [IW-1:0] id, input logic [63:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
        bit ok;
        ok = 1'b0;
        s_axi_arid = id; s_axi_araddr = addr; s_axi_arlen = len;
        s_axi_arsize = size; s_axi_arburst = burst; s_axi_arvalid = 1'b1;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            ok = s_axi_arready;
            @(posedge clk); #1;
        end
        s_axi_arvalid = 1'b0;
        if (!ok) timeout("ar_handshake");
    endtask

    task automatic wait_r_done();
        for (int i = 0; i < 400 && r_q.size() != 0; i++) @(posedge clk);
        #1;
        chk("r_beats_outstanding", r_q.size(), 0);
        chk("arready_after_burst", s_axi_arready, 1'b1);
    endtask

    task automatic w_start(input logic [IW-1:0] id, input logic [63:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst,
                           input int nbeats, input int last_at, input logic [1:0] exp_resp,
                           input logic [63:0] dat0, input logic [63:0] dinc,
                           input int sp_beat, input logic [7:0] sp_strb, input logic [63:0] sp_dat);
        bit ok;
        bexp_t e;
        e.id = id; e.resp = exp_resp;
        b_q.push_back(e);
        ac_q.push_back(addr & ~64'h3F);
        s_axi_awid = id; s_axi_awaddr = addr; s_axi_awlen = len;
        s_axi_awsize = size; s_axi_awburst = burst; s_axi_awvalid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            ok = s_axi_awready;
            @(posedge clk); #1;
        end
        s_axi_awvalid = 1'b0;
        if (!ok) timeout("aw_handshake");
        for (int i = 0; i < nbeats; i++) begin
            s_axi_wdata  = (i == sp_beat) ? sp_dat : dat0 + dinc * 64'(i);
            s_axi_wstrb  = (i == sp_beat) ? sp_strb : 8'hFF;
            s_axi_wlast  = (i == last_at);
            s_axi_wvalid = 1'b1;
            ok = 1'b0;
            for (int t = 0; t < 50 && !ok; t++) begin
                @(negedge clk);
                ok = s_axi_wready;
                @(posedge clk); #1;
            end
            if (!ok) timeout("w_handshake");
        end
        s_axi_wvalid = 1'b0;
        s_axi_wlast  = 1'b0;
        chk("bvalid_after_last_w", s_axi_bvalid, 1'b1);
        chk("wready_after_last_w", s_axi_wready, 1'b0);
    endtask

    task automatic wait_w_done();
        for (int i = 0; i < 100 && (b_q.size() != 0 || ac_q.size() != 0); i++) @(posedge clk);
        #1;
        chk("b_outstanding", b_q.size(), 0);
        chk("ac_outstanding", ac_q.size(), 0);
        chk("awready_after_ac", s_axi_awready, 1'b1);
    endtask

    // ---------------- read vector table ----------------
    typedef struct {
        logic [IW-1:0] id;
        logic [63:0]   addr;
        logic [7:0]    len;
        logic [2:0]    size;
        logic [1:0]    burst;
        logic [1:0]    resp;
        logic [7:0]    dat [16];
    } rvec_t;

    rvec_t vt [9];

    task automatic set_vec(input int n, input logic [IW-1:0] id, input logic [63:0] addr,
                           input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst,
                           input logic [1:0] resp);
        vt[n].id = id; vt[n].addr = addr; vt[n].len = len;
        vt[n].size = size; vt[n].burst = burst; vt[n].resp = resp;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        logic [3:0]  pat;
        logic [63:0] held;
        bit          prev_stall;

        reset = 1'b1;
        s_axi_arid = '0; s_axi_araddr = '0; s_axi_arlen = '0; s_axi_arsize = '0;
        s_axi_arburst = '0; s_axi_arvalid = 1'b0; s_axi_rready = 1'b1;
        s_axi_awid = '0; s_axi_awaddr = '0; s_axi_awlen = '0; s_axi_awsize = '0;
        s_axi_awburst = '0; s_axi_awvalid = 1'b0;
        s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wlast = 1'b0; s_axi_wvalid = 1'b0;
        s_axi_bready = 1'b1; s_axi_acready = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset state
        chk("rst_arready", s_axi_arready, 1'b1);
        chk("rst_awready", s_axi_awready, 1'b1);
        chk("rst_rvalid",  s_axi_rvalid,  1'b0);
        chk("rst_wready",  s_axi_wready,  1'b0);
        chk("rst_bvalid",  s_axi_bvalid,  1'b0);
        chk("rst_acvalid", s_axi_acvalid, 1'b0);
        chk("rst_rresp",   s_axi_rresp,   2'b00);
        chk("rst_bresp",   s_axi_bresp,   2'b00);
        chk("rst_rid",     s_axi_rid,     '0);
        chk("rst_bid",     s_axi_bid,     '0);
        chk("rst_acaddr",  s_axi_acaddr,  '0);
        chk("rst_acsnoop", s_axi_acsnoop, 4'hd);

        // Preload: words at 0x1000 hold 0..7, words at 0x3000 hold 0x30..0x3F, 0x2000 line zeroed
        w_start(13'h001, 64'h1000, 8'd7,  3'd3, 2'd1, 8,  7,  2'b00, 64'h0,  64'h1, -1, 8'h00, 64'h0);
        wait_w_done();
        w_start(13'h002, 64'h3000, 8'd15, 3'd3, 2'd1, 16, 15, 2'b00, 64'h30, 64'h1, -1, 8'h00, 64'h0);
        wait_w_done();
        w_start(13'h003, 64'h2000, 8'd7,  3'd3, 2'd1, 8,  7,  2'b00, 64'h0,  64'h0, -1, 8'h00, 64'h0);
        wait_w_done();

        // Strobed INCR write: beat 3 writes only the low 4 bytes over a zero word
        w_start(13'h004, 64'h2000, 8'd7, 3'd3, 2'd1, 8, 7, 2'b00, 64'h2000_0000, 64'h1,
                3, 8'h0F, 64'hAAAA_BBBB_CCCC_DDDD);
        wait_w_done();
        push_r(13'h009, 64'h0000_0000_CCCC_DDDD, 2'b00, 1'b1, 1'b1);
        ar_send(13'h009, 64'h2018, 8'd0, 3'd3, 2'd1);
        wait_r_done();

        // Malformed writes: SLVERR, full beat count consumed, RAM untouched
        w_start(13'h010, 64'h3000, 8'd1, 3'd3, 2'd3, 2, 1, 2'b10, 64'hDEAD_0000, 64'h1, -1, 8'h00, 64'h0);
        wait_w_done();
        w_start(13'h011, 64'h3000, 8'd1, 3'd2, 2'd1, 2, 1, 2'b10, 64'hBEEF_0000, 64'h1, -1, 8'h00, 64'h0);
        wait_w_done();
        w_start(13'h012, 64'h3000, 8'd2, 3'd3, 2'd2, 3, 2, 2'b10, 64'hCAFE_0000, 64'h1, -1, 8'h00, 64'h0);
        wait_w_done();

        // Beat-count mismatches: early wlast on beat 5 of 8, and no wlast on the final beat
        w_start(13'h020, 64'h4000, 8'd7, 3'd3, 2'd1, 5, 4,  2'b10, 64'h4000, 64'h1, -1, 8'h00, 64'h0);
        wait_w_done();
        w_start(13'h021, 64'h4100, 8'd3, 3'd3, 2'd1, 4, -1, 2'b10, 64'h4100, 64'h1, -1, 8'h00, 64'h0);
        wait_w_done();

        // Read table
        set_vec(0, 13'h0A5, 64'h1010, 8'd7,  3'd3, 2'd2, 2'b00);
        vt[0].dat = '{8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h00, 8'h01,
                      8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        set_vec(1, 13'h001, 64'h3000, 8'd15, 3'd3, 2'd1, 2'b00);
        vt[1].dat = '{8'h30, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37,
                      8'h38, 8'h39, 8'h3A, 8'h3B, 8'h3C, 8'h3D, 8'h3E, 8'h3F};
        set_vec(2, 13'h002, 64'h3008, 8'd3,  3'd3, 2'd0, 2'b00);
        vt[2].dat = '{8'h31, 8'h31, 8'h31, 8'h31, 8'h00, 8'h00, 8'h00, 8'h00,
                      8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        set_vec(3, 13'h003, 64'h3028, 8'd3,  3'd3, 2'd2, 2'b00);
        vt[3].dat = '{8'h35, 8'h36, 8'h37, 8'h34, 8'h00, 8'h00, 8'h00, 8'h00,
                      8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        set_vec(4, 13'h004, 64'h3000, 8'd3,  3'd2, 2'd1, 2'b10);
        vt[4].dat = '{default: 8'h00};
        set_vec(5, 13'h005, 64'h3000, 8'd1,  3'd3, 2'd3, 2'b10);
        vt[5].dat = '{default: 8'h00};
        set_vec(6, 13'h006, 64'h3000, 8'd2,  3'd3, 2'd2, 2'b10);
        vt[6].dat = '{default: 8'h00};
        set_vec(7, 13'h007, 64'h3070, 8'd1,  3'd3, 2'd2, 2'b00);
        vt[7].dat = '{8'h3E, 8'h3F, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                      8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        set_vec(8, 13'h008, 64'h3040, 8'd15, 3'd3, 2'd2, 2'b00);
        vt[8].dat = '{8'h38, 8'h39, 8'h3A, 8'h3B, 8'h3C, 8'h3D, 8'h3E, 8'h3F,
                      8'h30, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37};

        for (int n = 0; n < 9; n++) begin
            for (int i = 0; i <= int'(vt[n].len); i++)
                push_r(vt[n].id, {56'h0, vt[n].dat[i]}, vt[n].resp, i == int'(vt[n].len),
                       vt[n].resp == 2'b00);
            ar_send(vt[n].id, vt[n].addr, vt[n].len, vt[n].size, vt[n].burst);
            wait_r_done();
        end

        // rready stalls 1,0,0,1: R must hold while stalled
        for (int i = 0; i < 8; i++) push_r(13'h033, 64'h30 + 64'(i), 2'b00, i == 7, 1'b1);
        ar_send(13'h033, 64'h3000, 8'd7, 3'd3, 2'd1);
        chk("rvalid_latency", s_axi_rvalid, 1'b1);
        pat = 4'b1001;
        prev_stall = 1'b0;
        held = '0;
        for (int c = 0; c < 100 && r_q.size() != 0; c++) begin
            s_axi_rready = pat[c % 4];
            @(negedge clk);
            if (prev_stall) begin
                chk("rvalid_stall", s_axi_rvalid, 1'b1);
                chk("rdata_stall", s_axi_rdata, held);
            end
            prev_stall = s_axi_rvalid && !s_axi_rready;
            held = s_axi_rdata;
            @(posedge clk); #1;
        end
        s_axi_rready = 1'b1;
        wait_r_done();

        // acready held low: AC holds, no new AW accepted
        s_axi_acready = 1'b0;
        w_start(13'h055, 64'h5048, 8'd0, 3'd3, 2'd1, 1, 0, 2'b00, 64'h55, 64'h0, -1, 8'h00, 64'h0);
        for (int i = 0; i < 20 && !s_axi_acvalid; i++) begin @(posedge clk); #1; end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("acvalid_hold", s_axi_acvalid, 1'b1);
            chk("awready_during_ac", s_axi_awready, 1'b0);
        end
        @(posedge clk); #1;
        s_axi_acready = 1'b1;
        wait_w_done();

        // Reset during beat 4 of a read, then a fresh burst
        for (int i = 0; i < 8; i++) push_r(13'h077, 64'h30 + 64'(i), 2'b00, i == 7, 1'b1);
        ar_send(13'h077, 64'h3000, 8'd7, 3'd3, 2'd1);
        for (int i = 0; i < 100 && r_q.size() != 5; i++) begin @(posedge clk); #1; end
        s_axi_rready = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        s_axi_rready = 1'b1;
        chk("rvalid_after_reset", s_axi_rvalid, 1'b0);
        chk("arready_after_reset", s_axi_arready, 1'b1);
        chk("rresp_after_reset", s_axi_rresp, 2'b00);
        r_q.delete();
        push_r(13'h01F, 64'h2, 2'b00, 1'b0, 1'b1);
        push_r(13'h01F, 64'h3, 2'b00, 1'b0, 1'b1);
        push_r(13'h01F, 64'h0, 2'b00, 1'b0, 1'b1);
        push_r(13'h01F, 64'h1, 2'b00, 1'b1, 1'b1);
        ar_send(13'h01F, 64'h1010, 8'd3, 3'd3, 2'd2);
        wait_r_done();

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
